// File: rtl/sprite_flash_scheduler.sv
// Sprite flash scheduler: latches per-sprite triggers, loads the highest-priority
// sprite image through an external loader, then holds it on screen for a number of frames.
module sprite_flash_scheduler #(
    parameter int HOLD_FRAMES  = 8,
    parameter int LOAD_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] hit,
    input  logic        frame_tick,
    input  logic        load_done,
    output logic        load_req,
    output logic [3:0]  load_sel,
    output logic [3:0]  show_sel,
    output logic [13:0] pending,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [7:0]  HOLD_INIT    = 8'(HOLD_FRAMES);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOAD_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [13:0] pending_reg, pending_next;
    logic        load_req_reg, load_req_next;
    logic [3:0]  load_sel_reg, load_sel_next;
    logic [3:0]  show_sel_reg, show_sel_next;
    logic        timeout_err_reg, timeout_err_next;
    logic [7:0]  hold_reg, hold_next;
    logic [15:0] load_cnt_reg, load_cnt_next;

    logic [13:0] load_onehot;
    logic [13:0] show_onehot;
    logic [13:0] hit_blocked;
    logic [13:0] pending_clr;
    logic [3:0]  winner_code;
    logic        shown_hit;
    logic        hold_expired;

    // Decode the active codes back to bit positions; a trigger on the sprite
    // being loaded or shown must not queue it again.
    genvar gi;
    generate
        for (gi = 0; gi < 14; gi++) begin : g_code
            localparam logic [3:0] CODE = 4'(gi + 1);
            assign load_onehot[gi] = (load_sel_reg == CODE);
            assign show_onehot[gi] = (show_sel_reg == CODE);
            assign hit_blocked[gi] = ((state_reg == LOAD) && load_onehot[gi]) ||
                                     ((state_reg == SHOW) && show_onehot[gi]);
        end
    endgenerate

    // Ascending scan so the highest pending index is the one left standing.
    always_comb begin
        winner_code = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (pending_reg[i]) begin
                winner_code = 4'(i + 1);
            end
        end
    end

    assign shown_hit    = (state_reg == SHOW) && (|(hit & show_onehot));
    assign hold_expired = (state_reg == SHOW) && !shown_hit && frame_tick &&
                          (hold_reg == 8'd1);

    always_comb begin
        state_next       = state_reg;
        pending_clr      = 14'd0;
        load_req_next    = load_req_reg;
        load_sel_next    = load_sel_reg;
        show_sel_next    = show_sel_reg;
        timeout_err_next = 1'b0;
        hold_next        = hold_reg;
        load_cnt_next    = load_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (winner_code != 4'd0) begin
                    state_next    = LOAD;
                    load_req_next = 1'b1;
                    load_sel_next = winner_code;
                    load_cnt_next = 16'd0;
                end
            end

            LOAD: begin
                if (load_done) begin
                    pending_clr   = load_onehot;
                    show_sel_next = load_sel_reg;
                    load_req_next = 1'b0;
                    load_sel_next = 4'd0;
                    hold_next     = HOLD_INIT;
                    load_cnt_next = 16'd0;
                    state_next    = SHOW;
                end else if (load_cnt_reg >= TIMEOUT_LAST) begin
                    // Give up on this sprite; whatever is on screen stays there.
                    pending_clr      = load_onehot;
                    load_req_next    = 1'b0;
                    load_sel_next    = 4'd0;
                    timeout_err_next = 1'b1;
                    load_cnt_next    = 16'd0;
                    state_next       = IDLE;
                end else if (load_cnt_reg != 16'hFFFF) begin
                    load_cnt_next = load_cnt_reg + 16'd1;
                end
            end

            SHOW: begin
                if (shown_hit) begin
                    hold_next = HOLD_INIT;
                end else if (frame_tick && (hold_reg != 8'd0)) begin
                    hold_next = hold_reg - 8'd1;
                end

                if (hold_expired) begin
                    show_sel_next = 4'd0;
                end

                // Preemption keeps the old sprite up during the load unless its
                // hold runs out on this very edge.
                if (winner_code > show_sel_reg) begin
                    state_next    = LOAD;
                    load_req_next = 1'b1;
                    load_sel_next = winner_code;
                    load_cnt_next = 16'd0;
                end else if (hold_expired) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next    = IDLE;
                load_req_next = 1'b0;
                load_sel_next = 4'd0;
            end
        endcase

        pending_next = (pending_reg & ~pending_clr) | (hit & ~hit_blocked);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            pending_reg     <= 14'd0;
            load_req_reg    <= 1'b0;
            load_sel_reg    <= 4'd0;
            show_sel_reg    <= 4'd0;
            timeout_err_reg <= 1'b0;
            hold_reg        <= 8'd0;
            load_cnt_reg    <= 16'd0;
        end else begin
            state_reg       <= state_next;
            pending_reg     <= pending_next;
            load_req_reg    <= load_req_next;
            load_sel_reg    <= load_sel_next;
            show_sel_reg    <= show_sel_next;
            timeout_err_reg <= timeout_err_next;
            hold_reg        <= hold_next;
            load_cnt_reg    <= load_cnt_next;
        end
    end

    assign load_req    = load_req_reg;
    assign load_sel    = load_sel_reg;
    assign show_sel    = show_sel_reg;
    assign pending     = pending_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_sprite_flash_scheduler.sv
// Testbench for sprite_flash_scheduler: directed scenarios plus randomized traffic,
// all checked against an abstract per-cycle behavioural model.
module tb_sprite_flash_scheduler;

    localparam int HOLD    = 8;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset_n;
    logic [13:0] hit;
    logic        frame_tick;
    logic        load_done;
    logic        load_req;
    logic [3:0]  load_sel;
    logic [3:0]  show_sel;
    logic [13:0] pending;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = idle, 1 = loading, 2 = showing.
    int       m_mode;
    bit [13:0] m_pend;
    int       m_loading;
    int       m_showing;
    int       m_frames;
    int       m_age;
    bit       m_terr;

    sprite_flash_scheduler #(
        .HOLD_FRAMES (HOLD),
        .LOAD_TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hit        (hit),
        .frame_tick (frame_tick),
        .load_done  (load_done),
        .load_req   (load_req),
        .load_sel   (load_sel),
        .show_sel   (show_sel),
        .pending    (pending),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge given the inputs sampled at that edge.
    task automatic model_edge(input logic [13:0] h, input logic ft, input logic ld, input logic rn);
        int        top;
        int        old_show;
        bit [13:0] blocked;
        bit        gone;
        if (!rn) begin
            m_mode = 0; m_pend = '0; m_loading = 0; m_showing = 0;
            m_frames = 0; m_age = 0; m_terr = 0;
            return;
        end
        top = 0;
        for (int i = 13; i >= 0; i--) begin
            if (m_pend[i] && top == 0) top = i + 1;
        end
        blocked = '0;
        if (m_mode == 1 && m_loading != 0) blocked[m_loading-1] = 1'b1;
        if (m_mode == 2 && m_showing != 0) blocked[m_showing-1] = 1'b1;
        m_terr = 0;
        old_show = m_showing;
        case (m_mode)
            0: begin
                if (top != 0) begin
                    m_mode = 1; m_loading = top; m_age = 0;
                end
            end
            1: begin
                if (ld) begin
                    m_pend[m_loading-1] = 1'b0;
                    m_showing = m_loading; m_loading = 0;
                    m_frames = HOLD; m_mode = 2;
                end else if (m_age + 1 >= TIMEOUT) begin
                    m_pend[m_loading-1] = 1'b0;
                    m_loading = 0; m_terr = 1; m_mode = 0;
                end else begin
                    m_age++;
                end
            end
            default: begin
                gone = 0;
                if (old_show != 0 && h[old_show-1]) begin
                    m_frames = HOLD;
                end else if (ft && m_frames > 0) begin
                    m_frames--;
                    gone = (m_frames == 0);
                end
                if (gone) m_showing = 0;
                if (top > old_show) begin
                    m_mode = 1; m_loading = top; m_age = 0;
                end else if (gone) begin
                    m_mode = 0;
                end
            end
        endcase
        m_pend = m_pend | (h & ~blocked);
    endtask

    task automatic tick(input logic [13:0] h, input logic ft, input logic ld, input logic rn);
        @(negedge clk);
        hit = h; frame_tick = ft; load_done = ld; reset_n = rn;
        model_edge(h, ft, ld, rn);
        @(posedge clk);
        #1;
        chk("model_load_req", 16'(load_req), 16'(m_mode == 1));
        chk("model_load_sel", 16'(load_sel), 16'(m_loading));
        chk("model_show_sel", 16'(show_sel), 16'(m_showing));
        chk("model_pending", 16'(pending), 16'(m_pend));
        chk("model_timeout_err", 16'(timeout_err), 16'(m_terr));
    endtask

    initial begin
        hit = '0; frame_tick = 1'b0; load_done = 1'b0; reset_n = 1'b0;

        // Reset state
        tick(14'h0, 0, 0, 0);
        tick(14'h0, 0, 0, 0);
        chk("rst_load_req", 16'(load_req), 16'h0);
        chk("rst_show_sel", 16'(show_sel), 16'h0);
        chk("rst_pending", 16'(pending), 16'h0);

        // Single trigger, load, hold for exactly HOLD frames
        tick(14'h0004, 0, 0, 1);
        chk("s1_pending", 16'(pending), 16'h0004);
        chk("s1_no_req_yet", 16'(load_req), 16'h0);
        tick(14'h0, 0, 0, 1);
        chk("s1_load_req", 16'(load_req), 16'h1);
        chk("s1_load_sel", 16'(load_sel), 16'h3);
        tick(14'h0, 0, 0, 1);
        tick(14'h0, 0, 0, 1);
        chk("s1_sel_stable", 16'(load_sel), 16'h3);
        tick(14'h0, 0, 1, 1);
        chk("s1_show", 16'(show_sel), 16'h3);
        chk("s1_req_drop", 16'(load_req), 16'h0);
        for (int f = 1; f <= HOLD; f++) begin
            tick(14'h0, 1, 0, 1);
            chk("s1_hold", 16'(show_sel), (f < HOLD) ? 16'h3 : 16'h0);
            tick(14'h0, 0, 0, 1);
        end

        // Two simultaneous triggers: highest index first, lower one waits
        tick(14'h0, 0, 0, 0);
        tick(14'h2001, 0, 0, 1);
        tick(14'h0, 0, 0, 1);
        chk("s2_load_sel", 16'(load_sel), 16'hE);
        tick(14'h0, 0, 1, 1);
        chk("s2_show", 16'(show_sel), 16'hE);
        chk("s2_pending", 16'(pending), 16'h0001);
        for (int f = 1; f <= HOLD; f++) tick(14'h0, 1, 0, 1);
        chk("s2_expired", 16'(show_sel), 16'h0);
        tick(14'h0, 0, 0, 1);
        chk("s2_second_sel", 16'(load_sel), 16'h1);
        tick(14'h0, 0, 1, 1);
        chk("s2_second_show", 16'(show_sel), 16'h1);

        // Preemption by a higher code, then no preemption by a lower one
        tick(14'h0, 0, 0, 0);
        tick(14'h0010, 0, 0, 1);
        tick(14'h0, 0, 0, 1);
        tick(14'h0, 0, 1, 1);
        chk("s3_show5", 16'(show_sel), 16'h5);
        tick(14'h0200, 0, 0, 1);
        tick(14'h0, 0, 0, 1);
        chk("s3_preempt_sel", 16'(load_sel), 16'hA);
        chk("s3_old_shown", 16'(show_sel), 16'h5);
        tick(14'h0, 0, 1, 1);
        chk("s3_show10", 16'(show_sel), 16'hA);
        tick(14'h0004, 0, 0, 1);
        tick(14'h0, 0, 0, 1);
        chk("s3_no_preempt", 16'(load_req), 16'h0);
        chk("s3_wait_pending", 16'(pending), 16'h0004);

        // Re-trigger of the shown sprite reloads the hold
        tick(14'h0, 0, 0, 0);
        tick(14'h0040, 0, 0, 1);
        tick(14'h0, 0, 0, 1);
        tick(14'h0, 0, 1, 1);
        for (int f = 1; f <= HOLD - 2; f++) tick(14'h0, 1, 0, 1);
        tick(14'h0040, 0, 0, 1);
        chk("s4_pending", 16'(pending), 16'h0);
        for (int f = 1; f <= HOLD; f++) begin
            tick(14'h0, 1, 0, 1);
            chk("s4_hold", 16'(show_sel), (f < HOLD) ? 16'h7 : 16'h0);
        end

        // Load timeout
        tick(14'h0, 0, 0, 0);
        tick(14'h0100, 0, 0, 1);
        tick(14'h0, 0, 0, 1);
        chk("s5_load_sel", 16'(load_sel), 16'h9);
        for (int n = 2; n <= TIMEOUT; n++) begin
            tick(14'h0, 0, 0, 1);
            chk("s5_still_req", 16'(load_req), 16'h1);
        end
        tick(14'h0, 0, 0, 1);
        chk("s5_terr", 16'(timeout_err), 16'h1);
        chk("s5_req_off", 16'(load_req), 16'h0);
        chk("s5_pend_clr", 16'(pending), 16'h0);
        tick(14'h0, 0, 0, 1);
        chk("s5_terr_pulse", 16'(timeout_err), 16'h0);

        // Reset in the middle of a load
        tick(14'h3000, 0, 0, 1);
        tick(14'h0, 0, 0, 1);
        chk("s6_load_sel", 16'(load_sel), 16'hE);
        tick(14'h0, 0, 0, 0);
        chk("s6_rst_req", 16'(load_req), 16'h0);
        chk("s6_rst_pend", 16'(pending), 16'h0);
        tick(14'h3000, 0, 0, 0);
        chk("s6_hit_in_rst", 16'(pending), 16'h0);
        for (int n = 0; n < 3; n++) tick(14'h0, 0, 1, 1);
        chk("s6_no_req", 16'(load_req), 16'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [13:0] h;
            h = ($urandom_range(0, 5) == 0) ? (14'($urandom) & 14'($urandom)) : 14'h0;
            tick(h, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 199) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
